bc_score_sequencer: RTL and testbench

//  Sequenced scorer for the Bulls-and-Cows game: on a start request from the game FSM
//  (entered at S_CALCULATE) it snapshots Secret/Guess, scans all digit pairs one compare
//  per cycle and returns Count_A (right digit, right place) and Count_B (right digit,

---
 rtl/bc_pkg.sv | 13 +
 rtl/bc_score_sequencer.sv | 131 +++++++++++++
 tb/tb_bc_score_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bc_pkg.sv
// Shared Bulls-and-Cows constants and scorer state encoding; also imported by the game FSM.
package bc_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int MAX_TURNS  = 7;
    localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 4'hA;

    typedef enum logic [1:0] {
        SC_IDLE,
        SC_SCAN,
        SC_DONE
    } score_state_t;
endpackage

// File: rtl/bc_score_sequencer.sv
// Sequenced Bulls-and-Cows scorer: snapshots Secret/Guess on start, walks every
// guess/secret digit pair one compare per cycle, then reports A/B counts, win and game-over.
module bc_score_sequencer
    import bc_pkg::*;
#(
    parameter int                 NUM_DIGITS = bc_pkg::NUM_DIGITS,
    parameter int                 DIGIT_W    = bc_pkg::DIGIT_W,
    parameter int                 MAX_TURNS  = bc_pkg::MAX_TURNS,
    parameter logic [DIGIT_W-1:0] BLANK      = bc_pkg::DIGIT_BLANK
) (
    input  logic                              clk,
    input  logic                              RESET_N,
    input  logic                              start,
    input  logic                              abort,
    input  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] Secret,
    input  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] Guess,
    input  logic [2:0]                        turn_count,
    output logic                              busy,
    output logic                              done,
    output logic [2:0]                        count_a,
    output logic [2:0]                        count_b,
    output logic                              win,
    output logic                              game_over_req,
    output logic                              err_blank
);
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CMAX = CW'(NUM_DIGITS);

    score_state_t state_q, state_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] s_q, g_q;
    logic [2:0]    tc_q;
    logic [IW-1:0] i_q, j_q;
    logic [CW-1:0] ca_q, cb_q;
    logic          done_q, win_q, gor_q, err_q;
    logic          hit, has_blank;

    always_comb begin
        has_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (Secret[k] == BLANK || Guess[k] == BLANK) has_blank = 1'b1;

        hit = (g_q[i_q] == s_q[j_q]);

        state_d = state_q;
        case (state_q)
            SC_IDLE: if (start) state_d = has_blank ? SC_DONE : SC_SCAN;
            SC_SCAN: if (i_q == LAST && j_q == LAST) state_d = SC_DONE;
            SC_DONE: state_d = SC_IDLE;
            default: state_d = SC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= SC_IDLE;
            s_q     <= '0;
            g_q     <= '0;
            tc_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            ca_q    <= '0;
            cb_q    <= '0;
            done_q  <= 1'b0;
            win_q   <= 1'b0;
            gor_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (abort) begin
            state_q <= SC_IDLE;
            s_q     <= '0;
            g_q     <= '0;
            tc_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            ca_q    <= '0;
            cb_q    <= '0;
            done_q  <= 1'b0;
            win_q   <= 1'b0;
            gor_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                SC_IDLE: if (start) begin
                    s_q   <= Secret;
                    g_q   <= Guess;
                    tc_q  <= turn_count;
                    i_q   <= '0;
                    j_q   <= '0;
                    ca_q  <= '0;
                    cb_q  <= '0;
                    win_q <= 1'b0;
                    gor_q <= 1'b0;
                    err_q <= has_blank;
                end
                SC_SCAN: begin
                    // Duplicate digits can overcount; saturate rather than wrap.
                    if (hit) begin
                        if (i_q == j_q) begin
                            if (ca_q != CMAX) ca_q <= ca_q + 1'b1;
                        end else begin
                            if (cb_q != CMAX) cb_q <= cb_q + 1'b1;
                        end
                    end
                    if (j_q == LAST) begin
                        j_q <= '0;
                        i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                SC_DONE: begin
                    done_q <= 1'b1;
                    win_q  <= (ca_q == CMAX);
                    gor_q  <= (ca_q == CMAX) || (tc_q == 3'(MAX_TURNS - 1));
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state_q != SC_IDLE);
    assign done          = done_q;
    assign count_a       = 3'(ca_q);
    assign count_b       = 3'(cb_q);
    assign win           = win_q;
    assign game_over_req = gor_q;
    assign err_blank     = err_q;
endmodule

// File: tb/tb_bc_score_sequencer.sv
// Scoreboard bench: the driver queues hand-computed results, a negedge monitor checks each done.
module tb_bc_score_sequencer;
    logic             clk = 1'b0;
    logic             RESET_N = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [3:0][3:0]  Secret = '0;
    logic [3:0][3:0]  Guess = '0;
    logic [2:0]       turn_count = '0;
    logic             busy, done, win, game_over_req, err_blank;
    logic [2:0]       count_a, count_b;

    typedef struct {
        string      name;
        logic [2:0] a;
        logic [2:0] b;
        logic       w;
        logic       g;
        logic       e;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    bc_score_sequencer dut (
        .clk(clk), .RESET_N(RESET_N), .start(start), .abort(abort),
        .Secret(Secret), .Guess(Guess), .turn_count(turn_count),
        .busy(busy), .done(done), .count_a(count_a), .count_b(count_b),
        .win(win), .game_over_req(game_over_req), .err_blank(err_blank)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, expv, cyc);
        end
    endtask

    task automatic chk_idle_zero(input string n);
        chk({n, ".busy"}, busy, 0);
        chk({n, ".done"}, done, 0);
        chk({n, ".a"}, count_a, 0);
        chk({n, ".b"}, count_b, 0);
        chk({n, ".win"}, win, 0);
        chk({n, ".gor"}, game_over_req, 0);
        chk({n, ".err"}, err_blank, 0);
    endtask

    always @(negedge clk) begin
        if (RESET_N && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, ".lat"}, cyc, e.cyc);
                chk({e.name, ".a"}, count_a, e.a);
                chk({e.name, ".b"}, count_b, e.b);
                chk({e.name, ".win"}, win, e.w);
                chk({e.name, ".gor"}, game_over_req, e.g);
                chk({e.name, ".err"}, err_blank, e.e);
                chk({e.name, ".busy"}, busy, 0);
            end
        end
    end

    // Called at a negedge; start is sampled at the next posedge.
    task automatic issue(input string n, input logic [15:0] s, input logic [15:0] g,
                         input logic [2:0] tc, input bit push,
                         input logic [2:0] a, input logic [2:0] b,
                         input logic w, input logic go, input logic e, input int lat);
        exp_t x;
        Secret = s;
        Guess = g;
        turn_count = tc;
        start = 1'b1;
        if (push) begin
            x.name = n; x.a = a; x.b = b; x.w = w; x.g = go; x.e = e;
            x.cyc = cyc + 1 + lat;
            exp_q.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string n);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        chk({n, ".drain"}, exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        RESET_N = 1'b1;
        @(negedge clk);

        issue("exact", 16'h1234, 16'h1234, 3'd0, 1, 3'd4, 3'd0, 1, 1, 0, 17);
        chk("exact.busy_scan", busy, 1);
        drain("exact");

        issue("swap4", 16'h1234, 16'h4321, 3'd0, 1, 3'd0, 3'd4, 0, 0, 0, 17);
        drain("swap4");

        issue("ab22", 16'h1234, 16'h1243, 3'd2, 1, 3'd2, 3'd2, 0, 0, 0, 17);
        drain("ab22");

        issue("blank", 16'h1234, 16'h12A4, 3'd0, 1, 3'd0, 3'd0, 0, 0, 1, 1);
        drain("blank");
        chk("blank.hold_err", err_blank, 1);

        // Second start mid-SCAN with a new guess must be ignored.
        issue("ignore", 16'h1234, 16'h1234, 3'd0, 1, 3'd4, 3'd0, 1, 1, 0, 17);
        @(negedge clk);
        issue("ignore2", 16'h1234, 16'h5678, 3'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0);
        Guess = 16'h5678;
        drain("ignore");
        chk("ignore.hold_a", count_a, 4);

        // Abort a fresh run: no done, everything back to reset values.
        issue("abort", 16'h1234, 16'h1234, 3'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle_zero("abort");
        repeat (20) @(negedge clk);
        chk("abort.still_idle", busy, 0);

        issue("last_turn", 16'h1234, 16'h1356, 3'd6, 1, 3'd1, 3'd1, 0, 1, 0, 17);
        drain("last_turn");

        // Async reset in the middle of a scan.
        issue("rst", 16'h1234, 16'h1234, 3'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0);
        repeat (6) @(negedge clk);
        chk("rst.busy_before", busy, 1);
        chk("rst.a_before", count_a, 2);
        #2 RESET_N = 1'b0;
        #1 chk_idle_zero("rst_async");
        @(negedge clk);
        RESET_N = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst.still_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
